// File: rtl/ac_cfg_pkg.sv
// SSM2603 configuration table and acDriver i2c Avalon slave register map.
// Shared by the sequencer top and its byte-transfer engine.
package ac_cfg_pkg;

  typedef struct packed {
    logic [6:0] adr;
    logic [8:0] data;
    logic       dly;
  } acCfgEntry_t;

  localparam int N_TBL = 12;

  // 24-bit left-justified; R15 reset first, R6 power-up last after R9 activate
  localparam acCfgEntry_t CFG_TBL [N_TBL] = '{
    '{adr: 7'd15, data: 9'h000, dly: 1'b1},
    '{adr: 7'd6,  data: 9'h072, dly: 1'b0},
    '{adr: 7'd0,  data: 9'h017, dly: 1'b0},
    '{adr: 7'd1,  data: 9'h017, dly: 1'b0},
    '{adr: 7'd2,  data: 9'h079, dly: 1'b0},
    '{adr: 7'd3,  data: 9'h079, dly: 1'b0},
    '{adr: 7'd4,  data: 9'h012, dly: 1'b0},
    '{adr: 7'd5,  data: 9'h000, dly: 1'b0},
    '{adr: 7'd7,  data: 9'h009, dly: 1'b0},
    '{adr: 7'd8,  data: 9'h000, dly: 1'b0},
    '{adr: 7'd9,  data: 9'h001, dly: 1'b1},
    '{adr: 7'd6,  data: 9'h062, dly: 1'b0}
  };

  localparam logic [1:0] I2C_ADR_TXDATA = 2'd0;
  localparam logic [1:0] I2C_ADR_CMD    = 2'd1;
  localparam logic [1:0] I2C_ADR_STATUS = 2'd2;
  localparam logic [1:0] I2C_ADR_IRQCLR = 2'd3;

  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  localparam int STAT_NACK_BIT = 1;

endpackage

// File: rtl/ac_cfg_byte_xfer.sv
// Pushes one byte (or a bare command) through the acDriver i2c Avalon slave
// and reports completion with the sampled NACK flag.
module ac_cfg_byte_xfer
  import ac_cfg_pkg::*;
(
  input  logic       mstClk,
  input  logic       mstResetN,
  input  logic       go,
  input  logic       cmdOnly,
  input  logic [7:0] txByte,
  input  logic [3:0] cmd,
  output logic       rdy,
  output logic       nack,
  output logic [1:0] i2cAvsAdr,
  output logic       i2cAvsWr,
  output logic [7:0] i2cAvsWrData,
  output logic       i2cAvsRd,
  input  logic [7:0] i2cAvsRdData,
  input  logic       i2cIrq
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_DATA  = 3'd1;
  localparam logic [2:0] S_WR_CMD   = 3'd2;
  localparam logic [2:0] S_WAIT_IRQ = 3'd3;
  localparam logic [2:0] S_CLR_IRQ  = 3'd4;
  localparam logic [2:0] S_RD_STAT  = 3'd5;
  localparam logic [2:0] S_CHK      = 3'd6;

  logic [2:0] state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic [3:0] cmd_q, cmd_d;
  logic       cmdOnly_q, cmdOnly_d;
  logic       stat_unused;

  assign stat_unused = ^{i2cAvsRdData[7:2], i2cAvsRdData[0]};

  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    cmd_d        = cmd_q;
    cmdOnly_d    = cmdOnly_q;
    rdy          = 1'b0;
    nack         = 1'b0;
    i2cAvsAdr    = 2'd0;
    i2cAvsWr     = 1'b0;
    i2cAvsWrData = 8'h00;
    i2cAvsRd     = 1'b0;
    case (state_q)
      S_IDLE: if (go) begin
        byte_d    = txByte;
        cmd_d     = cmd;
        cmdOnly_d = cmdOnly;
        state_d   = cmdOnly ? S_WR_CMD : S_WR_DATA;
      end
      S_WR_DATA: begin
        i2cAvsWr     = 1'b1;
        i2cAvsAdr    = I2C_ADR_TXDATA;
        i2cAvsWrData = byte_q;
        state_d      = S_WR_CMD;
      end
      S_WR_CMD: begin
        i2cAvsWr     = 1'b1;
        i2cAvsAdr    = I2C_ADR_CMD;
        i2cAvsWrData = {4'b0000, cmd_q};
        // a bare STOP produces no byte, so there is nothing to wait for
        if (cmdOnly_q) begin
          rdy     = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_IRQ;
        end
      end
      S_WAIT_IRQ: if (i2cIrq) state_d = S_CLR_IRQ;
      S_CLR_IRQ: begin
        i2cAvsWr  = 1'b1;
        i2cAvsAdr = I2C_ADR_IRQCLR;
        state_d   = S_RD_STAT;
      end
      S_RD_STAT: begin
        i2cAvsRd  = 1'b1;
        i2cAvsAdr = I2C_ADR_STATUS;
        state_d   = S_CHK;
      end
      S_CHK: begin
        rdy     = 1'b1;
        nack    = i2cAvsRdData[STAT_NACK_BIT];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mstClk or negedge mstResetN) begin
    if (!mstResetN) begin
      state_q   <= S_IDLE;
      byte_q    <= 8'h00;
      cmd_q     <= 4'h0;
      cmdOnly_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      cmd_q     <= cmd_d;
      cmdOnly_q <= cmdOnly_d;
    end
  end

endmodule

// File: rtl/ac_cfg_sequencer.sv
// SSM2603 configuration sequencer: replays CFG_TBL with per-register NACK retry,
// then serves single host register writes between table runs.
module ac_cfg_sequencer
  import ac_cfg_pkg::*;
#(
  parameter int         CLK_MASTER_FRQ = 50_000_000,
  parameter logic [6:0] DEV_ADR        = 7'h1A,
  parameter int         N_RETRY        = 3,
  parameter int         DELAY_US       = 100,
  parameter bit         AUTO_START     = 1'b1
) (
  input  logic       mstClk,
  input  logic       mstResetN,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [4:0] errIdx,
  input  logic       hostReq,
  input  logic [6:0] hostRegAdr,
  input  logic [8:0] hostRegData,
  output logic       hostAck,
  output logic [1:0] i2cAvsAdr,
  output logic       i2cAvsWr,
  output logic [7:0] i2cAvsWrData,
  output logic       i2cAvsRd,
  input  logic [7:0] i2cAvsRdData,
  input  logic       i2cIrq
);

  localparam int DLY_RAW = CLK_MASTER_FRQ / 1_000_000 * DELAY_US;
  localparam int DLY_CYC = (DLY_RAW < 1) ? 1 : DLY_RAW;
  localparam int DW      = $clog2(DLY_CYC + 1);
  localparam int RW      = (N_RETRY < 1) ? 1 : $clog2(N_RETRY + 1);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_LOAD  = 4'd1;
  localparam logic [3:0] S_XFER  = 4'd2;
  localparam logic [3:0] S_NEXT  = 4'd3;
  localparam logic [3:0] S_DELAY = 4'd4;
  localparam logic [3:0] S_DONE  = 4'd5;
  localparam logic [3:0] S_HOST  = 4'd6;
  localparam logic [3:0] S_HACK  = 4'd7;
  localparam logic [3:0] S_STOP  = 4'd8;
  localparam logic [3:0] S_ERR   = 4'd9;

  logic [3:0]    state_q, state_d;
  logic [4:0]    tblIdx_q, tblIdx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [1:0]    bIdx_q, bIdx_d;
  logic [6:0]    adr_q, adr_d;
  logic [8:0]    data_q, data_d;
  logic          dly_q, dly_d;
  logic          isHost_q, isHost_d;
  logic          inFlight_q, inFlight_d;
  logic [DW-1:0] dlyCnt_q, dlyCnt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [4:0]    errIdx_q, errIdx_d;
  logic          autoPend_q;

  logic          startEff, lastEntry;
  logic          xGo, xCmdOnly, xRdy, xNack;
  logic [7:0]    xByte;
  logic [3:0]    xCmd;
  acCfgEntry_t   ent;

  assign startEff  = start | autoPend_q;
  assign lastEntry = (tblIdx_q == 5'(N_TBL - 1));
  assign ent       = CFG_TBL[tblIdx_q[3:0]];
  assign xCmdOnly  = (state_q == S_STOP);
  assign xGo       = ((state_q == S_XFER) || (state_q == S_STOP)) && !inFlight_q;

  always_comb begin
    xByte = 8'h00;
    xCmd  = CMD_STOP;
    if (state_q != S_STOP) begin
      case (bIdx_q)
        2'd0:    begin xByte = {DEV_ADR, 1'b0};       xCmd = CMD_START | CMD_WRITE; end
        2'd1:    begin xByte = {adr_q, data_q[8]};    xCmd = CMD_WRITE;             end
        default: begin xByte = data_q[7:0];           xCmd = CMD_WRITE | CMD_STOP;  end
      endcase
    end
  end

  ac_cfg_byte_xfer u_xfer (
    .mstClk       (mstClk),
    .mstResetN    (mstResetN),
    .go           (xGo),
    .cmdOnly      (xCmdOnly),
    .txByte       (xByte),
    .cmd          (xCmd),
    .rdy          (xRdy),
    .nack         (xNack),
    .i2cAvsAdr    (i2cAvsAdr),
    .i2cAvsWr     (i2cAvsWr),
    .i2cAvsWrData (i2cAvsWrData),
    .i2cAvsRd     (i2cAvsRd),
    .i2cAvsRdData (i2cAvsRdData),
    .i2cIrq       (i2cIrq)
  );

  always_comb begin
    state_d    = state_q;
    tblIdx_d   = tblIdx_q;
    retry_d    = retry_q;
    bIdx_d     = bIdx_q;
    adr_d      = adr_q;
    data_d     = data_q;
    dly_d      = dly_q;
    isHost_d   = isHost_q;
    dlyCnt_d   = dlyCnt_q;
    done_d     = done_q;
    err_d      = err_q;
    errIdx_d   = errIdx_q;
    inFlight_d = xRdy ? 1'b0 : (xGo ? 1'b1 : inFlight_q);
    case (state_q)
      S_IDLE: begin
        // start outranks a host request arriving in the same cycle
        if (startEff) begin
          done_d   = 1'b0;
          err_d    = 1'b0;
          tblIdx_d = 5'd0;
          retry_d  = '0;
          isHost_d = 1'b0;
          state_d  = S_LOAD;
        end else if (hostReq) begin
          adr_d    = hostRegAdr;
          data_d   = hostRegData;
          dly_d    = 1'b0;
          retry_d  = '0;
          isHost_d = 1'b1;
          state_d  = S_HOST;
        end
      end
      S_LOAD: begin
        adr_d   = ent.adr;
        data_d  = ent.data;
        dly_d   = ent.dly;
        bIdx_d  = 2'd0;
        state_d = S_XFER;
      end
      S_HOST: begin
        bIdx_d  = 2'd0;
        state_d = S_XFER;
      end
      S_XFER: if (xRdy) begin
        if (xNack)              state_d = S_STOP;
        else if (bIdx_q == 2'd2) state_d = isHost_q ? S_HACK : S_NEXT;
        else                    bIdx_d  = bIdx_q + 2'd1;
      end
      S_STOP: if (xRdy) begin
        if (retry_q == RW'(N_RETRY)) begin
          state_d = S_ERR;
        end else begin
          retry_d = retry_q + RW'(1);
          bIdx_d  = 2'd0;
          state_d = S_XFER;
        end
      end
      S_NEXT: begin
        retry_d  = '0;
        dlyCnt_d = '0;
        if (dly_q)          state_d = S_DELAY;
        else if (lastEntry) state_d = S_DONE;
        else begin
          tblIdx_d = tblIdx_q + 5'd1;
          state_d  = S_LOAD;
        end
      end
      S_DELAY: begin
        if (dlyCnt_q != DW'(DLY_CYC - 1)) dlyCnt_d = dlyCnt_q + DW'(1);
        else if (lastEntry)              state_d  = S_DONE;
        else begin
          tblIdx_d = tblIdx_q + 5'd1;
          state_d  = S_LOAD;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_HACK: state_d = S_IDLE;
      S_ERR: begin
        err_d = 1'b1;
        if (!isHost_q) errIdx_d = tblIdx_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mstClk or negedge mstResetN) begin
    if (!mstResetN) begin
      state_q    <= S_IDLE;
      tblIdx_q   <= 5'd0;
      retry_q    <= '0;
      bIdx_q     <= 2'd0;
      adr_q      <= 7'd0;
      data_q     <= 9'd0;
      dly_q      <= 1'b0;
      isHost_q   <= 1'b0;
      inFlight_q <= 1'b0;
      dlyCnt_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      errIdx_q   <= 5'd0;
      autoPend_q <= AUTO_START;
    end else begin
      state_q    <= state_d;
      tblIdx_q   <= tblIdx_d;
      retry_q    <= retry_d;
      bIdx_q     <= bIdx_d;
      adr_q      <= adr_d;
      data_q     <= data_d;
      dly_q      <= dly_d;
      isHost_q   <= isHost_d;
      inFlight_q <= inFlight_d;
      dlyCnt_q   <= dlyCnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      errIdx_q   <= errIdx_d;
      autoPend_q <= 1'b0;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign err     = err_q;
  assign errIdx  = errIdx_q;
  assign hostAck = (state_q == S_HACK) || ((state_q == S_ERR) && isHost_q);

endmodule

// File: tb/tb_ac_cfg_sequencer.sv
// Directed bench for ac_cfg_sequencer with a behavioural acDriver i2c slave
// that logs every byte sent and can NACK a chosen second byte.
module tb_ac_cfg_sequencer;

  localparam int DLY = 20;

  logic       mstClk = 1'b0;
  logic       mstResetN = 1'b0;
  logic       start = 1'b0;
  logic       hostReq = 1'b0;
  logic [6:0] hostRegAdr = 7'd0;
  logic [8:0] hostRegData = 9'd0;
  logic       busy, done, err, hostAck;
  logic [4:0] errIdx;
  logic [1:0] i2cAvsAdr;
  logic       i2cAvsWr, i2cAvsRd;
  logic [7:0] i2cAvsWrData;
  logic [7:0] i2cAvsRdData = 8'h00;
  logic       i2cIrq = 1'b0;

  ac_cfg_sequencer #(.CLK_MASTER_FRQ(1_000_000), .DEV_ADR(7'h1A), .N_RETRY(3),
                     .DELAY_US(DLY), .AUTO_START(1'b1)) dut (
    .mstClk(mstClk), .mstResetN(mstResetN), .start(start), .busy(busy), .done(done),
    .err(err), .errIdx(errIdx), .hostReq(hostReq), .hostRegAdr(hostRegAdr),
    .hostRegData(hostRegData), .hostAck(hostAck), .i2cAvsAdr(i2cAvsAdr),
    .i2cAvsWr(i2cAvsWr), .i2cAvsWrData(i2cAvsWrData), .i2cAvsRd(i2cAvsRd),
    .i2cAvsRdData(i2cAvsRdData), .i2cIrq(i2cIrq)
  );

  always #5 mstClk = ~mstClk;

  // i2c slave model
  logic       bfmClr = 1'b0;
  logic [7:0] nackVal = 8'h00;
  int         nackMax = 0;
  logic [7:0] txLog[$];
  int         cycLog[$];
  int         cyc = 0, stopCnt = 0, nackHits = 0, ackCnt = 0, bothCnt = 0, irqCnt = 0;
  logic [7:0] txData = 8'h00;
  logic [1:0] pos = 2'd0;
  logic       nackSt = 1'b0;

  always @(posedge mstClk) begin
    cyc <= cyc + 1;
    if (i2cAvsWr && i2cAvsRd) bothCnt <= bothCnt + 1;
    if (bfmClr) begin
      txLog.delete();
      cycLog.delete();
      stopCnt  <= 0;
      nackHits <= 0;
      ackCnt   <= 0;
    end else if (hostAck) begin
      ackCnt <= ackCnt + 1;
    end
    if (!mstResetN) begin
      i2cIrq       <= 1'b0;
      irqCnt       <= 0;
      pos          <= 2'd0;
      nackSt       <= 1'b0;
      i2cAvsRdData <= 8'h00;
    end else begin
      if (irqCnt != 0) begin
        irqCnt <= irqCnt - 1;
        if (irqCnt == 1) i2cIrq <= 1'b1;
      end
      if (i2cAvsRd && i2cAvsAdr == 2'd2) i2cAvsRdData <= {6'd0, nackSt, 1'b0};
      if (i2cAvsWr) begin
        case (i2cAvsAdr)
          2'd0: txData <= i2cAvsWrData;
          2'd1: begin
            if (i2cAvsWrData[2]) begin
              txLog.push_back(txData);
              cycLog.push_back(cyc);
              pos    <= i2cAvsWrData[0] ? 2'd0 : pos + 2'd1;
              i2cIrq <= 1'b0;
              irqCnt <= 3;
              if (!i2cAvsWrData[0] && pos == 2'd0 && txData == nackVal && nackHits < nackMax) begin
                nackSt   <= 1'b1;
                nackHits <= nackHits + 1;
              end else begin
                nackSt <= 1'b0;
              end
            end else if (i2cAvsWrData[1]) begin
              stopCnt <= stopCnt + 1;
            end
          end
          2'd3: i2cIrq <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_log();
    @(negedge mstClk) bfmClr = 1'b1;
    @(negedge mstClk) bfmClr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge mstClk) start = 1'b1;
    @(negedge mstClk) start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    repeat (3) @(negedge mstClk);
    while (busy && n < 5000) begin
      @(negedge mstClk);
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n, gapN;
    // reset state
    repeat (3) @(negedge mstClk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_avs", {30'd0, i2cAvsWr, i2cAvsRd}, 0);
    chk("rst_hostack", {31'd0, hostAck}, 0);

    // auto-start table, always ACK
    mstResetN = 1'b1;
    wait_idle("auto_idle");
    chk("auto_nbytes", txLog.size(), 36);
    chk("auto_b0", txLog[0], 8'h34);
    chk("auto_b1", txLog[1], 8'h1E);
    chk("auto_b2", txLog[2], 8'h00);
    chk("auto_last_b1", txLog[34], 8'h0C);
    chk("auto_last_b2", txLog[35], 8'h62);
    gapN = cycLog[6] - cycLog[5];
    chk("gap_r15", cycLog[3] - cycLog[2] - gapN, DLY);
    chk("gap_r9", cycLog[33] - cycLog[32] - gapN, DLY);
    chk("auto_done", {31'd0, done}, 1);
    chk("auto_err", {31'd0, err}, 0);
    chk("auto_stops", stopCnt, 0);

    // NACK b1 of entry 3 twice
    clr_log();
    nackVal = 8'h02; nackMax = 2;
    pulse_start();
    wait_idle("nack2_idle");
    chk("nack2_nbytes", txLog.size(), 40);
    chk("nack2_stops", stopCnt, 2);
    chk("nack2_retry1", txLog[11], 8'h34);
    chk("nack2_retry2", txLog[13], 8'h34);
    chk("nack2_b2", txLog[15], 8'h17);
    chk("nack2_done", {31'd0, done}, 1);
    chk("nack2_err", {31'd0, err}, 0);

    // entry 5 always NACKs
    clr_log();
    nackVal = 8'h06; nackMax = 1000;
    pulse_start();
    wait_idle("nackx_idle");
    chk("nackx_nbytes", txLog.size(), 23);
    chk("nackx_stops", stopCnt, 4);
    chk("nackx_lastbyte", txLog[22], 8'h06);
    chk("nackx_err", {31'd0, err}, 1);
    chk("nackx_erridx", {27'd0, errIdx}, 5);
    chk("nackx_done", {31'd0, done}, 0);

    // start and hostReq together; start while busy ignored
    clr_log();
    nackMax = 0;
    @(negedge mstClk);
    start = 1'b1; hostReq = 1'b1; hostRegAdr = 7'h02; hostRegData = 9'h1FF;
    @(negedge mstClk) start = 1'b0;
    repeat (40) @(negedge mstClk);
    chk("busy_mid", {31'd0, busy}, 1);
    pulse_start();
    n = 0;
    while (!hostAck && n < 5000) begin
      @(negedge mstClk);
      n++;
    end
    chk("host_ack_seen", {31'd0, hostAck}, 1);
    hostReq = 1'b0;
    wait_idle("host_idle");
    chk("host_nbytes", txLog.size(), 39);
    chk("host_tbl_first", txLog[0], 8'h34);
    chk("host_b0", txLog[36], 8'h34);
    chk("host_b1", txLog[37], 8'h05);
    chk("host_b2", txLog[38], 8'hFF);
    chk("host_ackcnt", ackCnt, 1);
    chk("host_done", {31'd0, done}, 1);
    chk("host_err", {31'd0, err}, 0);

    // plain host write after done
    clr_log();
    @(negedge mstClk);
    hostReq = 1'b1; hostRegAdr = 7'h04; hostRegData = 9'h079;
    n = 0;
    while (!hostAck && n < 2000) begin
      @(negedge mstClk);
      n++;
    end
    hostReq = 1'b0;
    wait_idle("host2_idle");
    chk("host2_nbytes", txLog.size(), 3);
    chk("host2_b1", txLog[1], 8'h08);
    chk("host2_b2", txLog[2], 8'h79);
    chk("host2_ackcnt", ackCnt, 1);

    // reset during WAIT_IRQ
    pulse_start();
    n = 0;
    while (!(i2cAvsWr && i2cAvsAdr == 2'd1) && n < 200) begin
      @(negedge mstClk);
      n++;
    end
    chk("rst_cmd_seen", {31'd0, i2cAvsWr}, 1);
    @(posedge mstClk);
    #2 mstResetN = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_done", {31'd0, done}, 0);
    chk("arst_avs", {30'd0, i2cAvsWr, i2cAvsRd}, 0);
    clr_log();
    @(negedge mstClk) mstResetN = 1'b1;
    wait_idle("rerun_idle");
    chk("rerun_nbytes", txLog.size(), 36);
    chk("rerun_b0", txLog[0], 8'h34);
    chk("rerun_done", {31'd0, done}, 1);
    chk("wr_rd_exclusive", bothCnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
